vga_scan_ctrl: RTL
==================

Name: vga_scan_ctrl

Overview:
VGA raster timing generator and scan-out stage that pairs with the GPU core. It drives hsync/vsync and produces the row coordinate (o_y) and frame counter (o_time) that the core consumes. Once per line it captures the core's 32-bit result word and scans that word out as four horizontal colour bands on the next displayed line. It sits between gpu_core and the board's VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
pix_ce  in  1  pixel clock enable; counters advance only when 1
gpu_data  in  32  core result word (gpu_core debug_out)
o_y  out  8  row index of the next line to display; to gpu_core i_y
o_time  out  8  frame counter; to gpu_core i_time
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
active  out  1  registered display-enable, aligned with RGB

Behaviour:
- H_TOTAL = sum of the H_* parameters (800 at defaults). V_TOTAL = sum of the V_* parameters (525 at defaults).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and v_cnt runs 0..V_TOTAL-1; both change only on cycles with pix_ce=1.
  - h_cnt wraps to 0 at H_TOTAL-1, and v_cnt increments on that same tick.
  - v_cnt wraps to 0 when it is at V_TOTAL-1 and h_cnt wraps.
- Reset (rst=0, asynchronous):
  - h_cnt, v_cnt, o_y, o_time, line_word, RGB and active all go to 0.
  - hsync and vsync go to the deasserted level (~SYNC_POL).
  - Reset mid-frame restarts scanning at pixel (0,0) on the first pix_ce after release. There is no partial-frame recovery.
- Sync and blanking, one pipeline register stage so everything is aligned with RGB:
  - hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE), registered.
  - Outputs reflect the counter values one pix_ce tick earlier (latency 1).
- o_y handshake (next-line prefetch):
  - On the tick where h_cnt becomes H_ACTIVE (start of horizontal blank), the next line index is nv = (v_cnt+1) mod V_TOTAL.
  - o_y <= nv[8:1] if nv < V_ACTIVE, otherwise 0. Row pairs share a value, giving 0..239.
  - o_y is stable for the entire blanking interval, so the core has at least H_FP+H_SYNC+H_BP = 160 pixel ticks to compute.
- Capture:
  - On the tick where h_cnt == H_TOTAL-1, line_word <= gpu_data.
  - line_word is held for the whole following line. The capture happens every line, including blank lines.
- Scan-out while active:
  - Byte select: byte3 for h < 160, byte2 for 160..319, byte1 for 320..479, byte0 for 480..639. Boundaries are H_ACTIVE/4 multiples.
  - Each byte is RGB332: r = {b[7:5], b[7]}, g = {b[4:2], b[4]}, b = {b[1:0], b[1:0]}.
  - When not active, RGB = 0.
- o_time increments on the tick where v_cnt wraps to 0, and wraps from 255 to 0.
- pix_ce = 0 freezes all state. Registered outputs hold their values.

Decomposition:
- Package vga_pkg holds:
  - the timing defaults (H_ACTIVE..V_BP) and the derived H_TOTAL/V_TOTAL;
  - the rgb444_t struct {r, g, b};
  - an rgb332_to_444 function.
- One natural sub-module, vga_sync_counter: h/v counters plus the sync/active decode. The top level holds the o_y, capture, o_time and pixel mux logic.

Test Plan:
1. Reset low for 3 clocks, then run with pix_ce = 1 → hsync and vsync are 1, RGB = 0 and o_time = 0 immediately during reset; the first hsync falling edge occurs 657 ticks after release; the hsync low width is 96 ticks; the period is 800.
2. Full frame → vsync is low for exactly 1600 ticks (2 lines) starting at line 490; o_time = 1 after 420000 ticks.
3. Hold gpu_data = 32'hE01C03FF and run two lines → line 1 shows red (F,0,0) on 0..159, green (0,F,0) on 160..319, blue (0,0,F) on 320..479, and white (F,F,F) on 480..639.
4. Change gpu_data mid-line → the displayed colours do not change until the line after the next capture point (h_cnt = 799).
5. Observe o_y across the frame → o_y = 0 during lines 0-1, becomes 1 at h=640 of line 1, reaches 239 at line 477, and returns to 0 at h=640 of line 479.
6. Toggle pix_ce every other clock and assert rst at line 300, pixel 400 → timing scales to half rate; after reset, counters restart at (0,0) and o_time = 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel colour type and RGB332 expansion helper
// for the raster scan-out slice.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam logic        SYNC_POL = 1'b0;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Widen each field by replicating its MSBs so full-scale stays full-scale.
  function automatic rgb444_t rgb332_to_444(input logic [7:0] c);
    rgb444_t p;
    p.r = {c[7:5], c[7]};
    p.g = {c[4:2], c[4]};
    p.b = {c[1:0], c[1:0]};
    return p;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with registered sync and display-enable
// decode; everything advances only on pixel clock-enable ticks.
module vga_sync_counter #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter logic        SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 pix_ce,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]         h_cnt,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]         v_cnt,
  output logic                                                 line_end,
  output logic                                                 v_last,
  output logic                                                 hblank_start,
  output logic                                                 pix_active,
  output logic                                                 hsync,
  output logic                                                 vsync,
  output logic                                                 active
);
  import vga_pkg::*;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_PRE    = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic in_hsync;
  logic in_vsync;

  always_comb begin
    line_end     = (h_cnt == H_LAST);
    v_last       = (v_cnt == V_LAST);
    hblank_start = (h_cnt == H_PRE);
    pix_active   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    in_hsync     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    in_vsync     = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  // Sync/enable are sampled from the pre-tick counters, giving one tick of
  // latency that lines them up with the registered RGB in the top level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
      active <= 1'b0;
    end else if (pix_ce) begin
      hsync  <= in_hsync ? SYNC_POL : ~SYNC_POL;
      vsync  <= in_vsync ? SYNC_POL : ~SYNC_POL;
      active <= pix_active;
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA timing generator and scan-out: prefetches the next row index for the
// GPU core, captures its result word once per line and paints four colour bands.
module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter logic        SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [31:0] gpu_data,
  output logic [7:0]  o_y,
  output logic [7:0]  o_time,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        active
);
  import vga_pkg::*;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);

  localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] BAND_1  = HW'(H_ACTIVE / 4);
  localparam logic [HW-1:0] BAND_2  = HW'(H_ACTIVE / 2);
  localparam logic [HW-1:0] BAND_3  = HW'((3 * H_ACTIVE) / 4);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          line_end;
  logic          v_last;
  logic          hblank_start;
  logic          pix_active;

  logic [31:0]   line_word;
  logic [VW-1:0] next_v;
  logic [7:0]    band_byte;
  rgb444_t       pix_rgb;
  rgb444_t       rgb_q;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_sync (
    .clk          (clk),
    .rst          (rst),
    .pix_ce       (pix_ce),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .line_end     (line_end),
    .v_last       (v_last),
    .hblank_start (hblank_start),
    .pix_active   (pix_active),
    .hsync        (hsync),
    .vsync        (vsync),
    .active       (active)
  );

  always_comb begin
    next_v = v_last ? '0 : v_cnt + VW'(1);
  end

  always_comb begin
    band_byte = line_word[7:0];
    if (h_cnt < BAND_1) begin
      band_byte = line_word[31:24];
    end else if (h_cnt < BAND_2) begin
      band_byte = line_word[23:16];
    end else if (h_cnt < BAND_3) begin
      band_byte = line_word[15:8];
    end
    pix_rgb = rgb332_to_444(band_byte);
  end

  // Row index is published at the start of horizontal blank so the core has
  // the whole blanking interval to produce the word captured at line end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_y <= '0;
    end else if (pix_ce && hblank_start) begin
      o_y <= (next_v < V_VIS) ? 8'(next_v >> 1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_word <= '0;
      o_time    <= '0;
      rgb_q     <= '0;
    end else if (pix_ce) begin
      rgb_q <= pix_active ? pix_rgb : '0;
      if (line_end) begin
        line_word <= gpu_data;
        if (v_last) begin
          o_time <= o_time + 8'd1;
        end
      end
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule
